// File: rtl/conv1d_lane_engine.sv
// Int8 1-D convolution window engine behind a CFU-style command port.
// LANES products per cycle through fetch / multiply-sum / accumulate stages.
module conv1d_lane_engine #(
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int LANES              = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  cmd,
    input  logic [31:0] inp0,
    input  logic [31:0] inp1,
    output logic [31:0] ret,
    output logic        busy
);
    localparam int BUF_DEPTH = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int PW = $clog2(BUF_DEPTH + 1) + 1;
    localparam int DW = $clog2(MAX_INPUT_CHANNELS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic signed [7:0]  in_mem  [BUF_DEPTH];
    logic signed [7:0]  flt_mem [BUF_DEPTH];

    state_t             state_q, state_d;
    logic signed [31:0] offset_q, acc_q;
    logic [DW-1:0]      depth_q;
    logic [31:0]        start_x_q;
    logic [2:0]         wwidth_q;
    logic               done_q, err_q;
    logic [31:0]        ret_q;
    logic [PW-1:0]      k_q, a_q, g_q, cs_run_q, n_last_q;
    logic               vld_p0, last_p0, vld_p1, last_p1;
    logic signed [7:0]  flt_p0 [LANES];
    logic signed [7:0]  in_p0  [LANES];
    logic signed [31:0] sum_p1, lane_sum;

    logic [PW-1:0]      cur_size;
    logic [32:0]        wr_last;
    logic               start_ok, wr_ok, issue, last_grp, fin;

    function automatic logic [PW-1:0] ring_idx(input logic [PW-1:0] base, input int lane,
                                               input logic [PW-1:0] size);
        logic [PW-1:0] raw;
        raw = base + PW'(lane);
        return (raw < size) ? raw : raw - size;
    endfunction

    function automatic logic signed [31:0] lane_prod(input logic signed [7:0] w,
                                                     input logic signed [7:0] x,
                                                     input logic signed [31:0] off);
        logic signed [31:0] wx, xo;
        wx = {{24{w[7]}}, w};
        xo = {{24{x[7]}}, x} + off;
        return wx * xo;
    endfunction

    assign cur_size = PW'(KERNEL_LENGTH) * PW'(depth_q);
    assign start_ok = (state_q == IDLE) && (depth_q != '0)
                      && ((cur_size % PW'(LANES)) == '0)
                      && (start_x_q < 32'(KERNEL_LENGTH));
    assign wr_last  = {1'b0, inp0} + 33'(wwidth_q) - 33'd1;
    assign wr_ok    = (state_q == IDLE) && (wr_last < 33'(BUF_DEPTH));
    assign issue    = (state_q == RUN);
    assign last_grp = (g_q == n_last_q);
    assign fin      = (state_q == DRAIN) && vld_p1 && last_p1;
    assign busy     = (state_q != IDLE);
    assign ret      = ret_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd == 7'd6 && start_ok) state_d = RUN;
            RUN:     if (last_grp) state_d = DRAIN;
            DRAIN:   if (fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cmd == 7'd17) state_d = IDLE;
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + lane_prod(flt_p0[i], in_p0[i], offset_q);
    end

    // Buffers and pipeline data: never reset, frozen with en
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (b < int'(wwidth_q) && wr_ok && cmd == 7'd1) in_mem[AW'(inp0 + 32'(b))]  <= inp1[8*b +: 8];
                if (b < int'(wwidth_q) && wr_ok && cmd == 7'd2) flt_mem[AW'(inp0 + 32'(b))] <= inp1[8*b +: 8];
            end
            // stage p0: operand fetch, each lane wrapping around the ring on its own
            if (issue) begin
                for (int i = 0; i < LANES; i++) begin
                    flt_p0[i] <= flt_mem[AW'(k_q + PW'(i))];
                    in_p0[i]  <= in_mem[AW'(ring_idx(a_q, i, cs_run_q))];
                end
            end
            // stage p1: lane products summed
            sum_p1 <= lane_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            depth_q   <= '0;
            start_x_q <= '0;
            wwidth_q  <= 3'd4;
            acc_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ret_q     <= '0;
            k_q       <= '0;
            a_q       <= '0;
            g_q       <= '0;
            cs_run_q  <= '0;
            n_last_q  <= '0;
            vld_p0    <= 1'b0;
            last_p0   <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            vld_p0  <= issue;
            last_p0 <= issue && last_grp;
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            // stage p2: accumulate
            if (vld_p1) acc_q <= acc_q + sum_p1;
            if (issue) begin
                k_q <= k_q + PW'(LANES);
                a_q <= ring_idx(a_q, LANES, cs_run_q);
                g_q <= g_q + PW'(1);
            end
            if (fin) done_q <= 1'b1;

            // Commands land after the pipeline so abort overrides a same-cycle finish
            case (cmd)
                7'd0: ret_q <= 32'(BUF_DEPTH);
                7'd1, 7'd2: if (!wr_ok) err_q <= 1'b1;
                7'd3: offset_q <= inp1;
                7'd5: begin
                    if (inp1 == 32'd0 || inp1 > 32'(MAX_INPUT_CHANNELS)) err_q <= 1'b1;
                    else depth_q <= DW'(inp1);
                end
                7'd6: begin
                    if (start_ok) begin
                        acc_q    <= '0;
                        done_q   <= 1'b0;
                        k_q      <= '0;
                        a_q      <= PW'(start_x_q) * PW'(depth_q);
                        g_q      <= '0;
                        cs_run_q <= cur_size;
                        n_last_q <= cur_size / PW'(LANES) - PW'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                7'd7: ret_q <= acc_q;
                7'd8: start_x_q <= inp1;
                7'd9: begin
                    ret_q <= {29'b0, err_q, busy, done_q};
                    err_q <= 1'b0;
                end
                7'd16: begin
                    if (inp1 == 32'd1 || inp1 == 32'd2 || inp1 == 32'd4) wwidth_q <= inp1[2:0];
                    else err_q <= 1'b1;
                end
                7'd17: begin
                    done_q <= 1'b0;
                    vld_p0 <= 1'b0;
                    vld_p1 <= 1'b0;
                end
                default: ret_q <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_lane_engine.sv
// Randomised self-checking bench for conv1d_lane_engine against a window dot-product model.
module tb_conv1d_lane_engine;
    localparam int KL        = 8;
    localparam int MIC       = 128;
    localparam int LANES     = 8;
    localparam int BUF_DEPTH = KL * MIC;
    localparam logic [6:0] IDLE_CMD = 7'h7F;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [6:0]  cmd;
    logic [31:0] inp0, inp1, ret;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    byte in_m  [BUF_DEPTH];
    byte flt_m [BUF_DEPTH];

    conv1d_lane_engine #(.KERNEL_LENGTH(KL), .MAX_INPUT_CHANNELS(MIC), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
        .ret(ret), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1);
        cmd  = c;
        inp0 = a0;
        inp1 = a1;
        tick();
        cmd  = IDLE_CMD;
    endtask

    task automatic wr_bytes(input bit is_flt, input int addr, input int w, input logic [31:0] val);
        do_cmd(is_flt ? 7'd2 : 7'd1, addr, val);
        for (int b = 0; b < w; b++) begin
            if (is_flt) flt_m[addr + b] = val[8*b +: 8];
            else        in_m[addr + b]  = val[8*b +: 8];
        end
    endtask

    task automatic fill_rand(input bit is_flt, input int n);
        int pick, w;
        pick = $urandom_range(0, 2);
        w = (pick == 0) ? 1 : (pick == 1) ? 2 : 4;
        do_cmd(7'd16, 0, w);
        for (int a = 0; a < n; a += w) wr_bytes(is_flt, a, w, $urandom);
    endtask

    // Window dot product straight from the definition: filter[j] against ring input from start_x*depth
    function automatic int model_acc(input int depth, input int sx, input int off);
        int cs, a0, acc;
        cs  = KL * depth;
        a0  = sx * depth;
        acc = 0;
        for (int j = 0; j < cs; j++)
            acc += int'(flt_m[j]) * (int'(in_m[(a0 + j) % cs]) + off);
        return acc;
    endfunction

    task automatic run_win(input string tag, input int exp_edges, input int gate_at,
                           input int restart_at, input int exp_acc);
        int e;
        e   = 0;
        cmd = 7'd6;
        tick();
        cmd = IDLE_CMD;
        check_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
        while (busy && e < 2000) begin
            if (e == gate_at)     en = 1'b0;
            if (e == gate_at + 5) en = 1'b1;
            cmd = (e == restart_at) ? 7'd6 : IDLE_CMD;
            tick();
            e++;
        end
        en  = 1'b1;
        cmd = IDLE_CMD;
        check_eq({tag, "_edges"}, e, exp_edges);
        do_cmd(7'd7, 0, 0);
        check_eq({tag, "_acc"}, ret, exp_acc);
    endtask

    task automatic err_case(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        do_cmd(7'd9, 0, 0);
        check_eq({tag, "_stat"}, ret, 32'd4);
        do_cmd(7'd9, 0, 0);
        check_eq({tag, "_clr"}, ret, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int depth, sx, off, ra;
        rst = 1'b1; en = 1'b1; cmd = IDLE_CMD; inp0 = '0; inp1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ret", ret, 32'd0);
        rst = 1'b0;
        tick();
        do_cmd(7'd0, 0, 0);  check_eq("buf_depth", ret, BUF_DEPTH);
        do_cmd(7'd9, 0, 0);  check_eq("status_reset", ret, 32'd0);
        do_cmd(7'd7, 0, 0);  check_eq("acc_reset", ret, 32'd0);

        // Basic window: input 0..7, filter all ones
        do_cmd(7'd5, 0, 1); do_cmd(7'd3, 0, 0); do_cmd(7'd8, 0, 0);
        wr_bytes(0, 0, 4, 32'h03020100); wr_bytes(0, 4, 4, 32'h07060504);
        wr_bytes(1, 0, 4, 32'h01010101); wr_bytes(1, 4, 4, 32'h01010101);
        run_win("basic", 3, -1, -1, model_acc(1, 0, 0));
        do_cmd(7'd9, 0, 0);  check_eq("status_done", ret, 32'd1);

        // Ring wrap with a single-tap filter
        wr_bytes(1, 0, 4, 32'h0); wr_bytes(1, 4, 4, 32'h00000100);
        do_cmd(7'd8, 0, 3); run_win("wrap3", 3, -1, -1, model_acc(1, 3, 0));
        do_cmd(7'd8, 0, 2); run_win("wrap2", 3, -1, -1, model_acc(1, 2, 0));

        // Negative offset over two groups
        do_cmd(7'd5, 0, 2); do_cmd(7'd8, 0, 0); do_cmd(7'd3, 0, 32'hFFFFFF80);
        for (int a = 0; a < 16; a += 4) begin
            wr_bytes(0, a, 4, 32'h0);
            wr_bytes(1, a, 4, 32'h01010101);
        end
        run_win("offset", 4, -1, -1, model_acc(2, 0, -128));

        // Random windows; one run also receives a start while busy
        for (int it = 0; it < 6; it++) begin
            depth = $urandom_range(1, 12);
            sx    = $urandom_range(0, KL - 1);
            off   = (it % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom);
            ra    = (it == 2) ? 1 : -1;
            fill_rand(0, KL * depth);
            fill_rand(1, KL * depth);
            do_cmd(7'd5, 0, depth); do_cmd(7'd8, 0, sx); do_cmd(7'd3, 0, off);
            run_win("rand", depth + 2, -1, ra, model_acc(depth, sx, off));
            do_cmd(7'd9, 0, 0);
            check_eq("rand_status", ret, (ra >= 0) ? 32'd5 : 32'd1);
        end

        // en gating stretches latency one-for-one, same result
        fill_rand(0, 32); fill_rand(1, 32);
        do_cmd(7'd5, 0, 4); do_cmd(7'd8, 0, 1); do_cmd(7'd3, 0, 5);
        run_win("ungated", 6, -1, -1, model_acc(4, 1, 5));
        run_win("gated", 11, 2, -1, model_acc(4, 1, 5));

        // Argument errors
        do_cmd(7'd16, 0, 4);
        do_cmd(7'd17, 0, 0);
        do_cmd(7'd9, 0, 0);  check_eq("status_abort_idle", ret, 32'd0);
        do_cmd(7'd5, 0, 0);                              err_case("depth0");
        do_cmd(7'd5, 0, MIC + 1);                        err_case("depth_big");
        do_cmd(7'd8, 0, KL); do_cmd(7'd6, 0, 0);         err_case("startx");
        do_cmd(7'd8, 0, 0);
        do_cmd(7'd16, 0, 3);                             err_case("width3");
        do_cmd(7'd1, BUF_DEPTH - 2, 32'hAABBCCDD);       err_case("addr_oob");
        wr_bytes(0, BUF_DEPTH - 4, 4, 32'h11223344);
        do_cmd(7'd9, 0, 0);  check_eq("addr_edge_ok", ret, 32'd0);

        // Abort at edge 10 of a long run
        do_cmd(7'd5, 0, MIC);
        cmd = 7'd6; tick(); cmd = IDLE_CMD;
        repeat (9) tick();
        check_eq("abort_pre_busy", 32'(busy), 32'd1);
        do_cmd(7'd17, 0, 0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        do_cmd(7'd9, 0, 0);  check_eq("abort_status", ret, 32'd0);

        // Asynchronous reset mid-run
        do_cmd(7'd16, 0, 2); do_cmd(7'd3, 0, 77);
        cmd = 7'd6; tick(); cmd = IDLE_CMD;
        repeat (4) tick();
        do_cmd(7'd0, 0, 0);
        check_eq("pre_rst_ret", ret, BUF_DEPTH);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_ret", ret, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_cmd(7'd9, 0, 0);  check_eq("post_rst_status", ret, 32'd0);
        do_cmd(7'd7, 0, 0);  check_eq("post_rst_acc", ret, 32'd0);
        do_cmd(7'd1, BUF_DEPTH - 3, 0);
        do_cmd(7'd9, 0, 0);  check_eq("post_rst_width4", ret, 32'd4);
        do_cmd(7'd6, 0, 0);
        check_eq("post_rst_depth0_busy", 32'(busy), 32'd0);
        do_cmd(7'd9, 0, 0);  check_eq("post_rst_depth0", ret, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
